// File: rtl/cipher_pkg.sv
// Shared AES-128 types, FSM encoding, S-box and round-constant tables for the
// iterative cipher controller and its combinational round datapath.
package cipher_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [0:3][0:3][7:0] state_t;   // [row][col] byte matrix

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  // Indexed directly by the 4-bit round counter; unused slots read as zero.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/cipher_round.sv
// One combinational AES round (SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey) together with the matching AES-128 key-expansion step.
module cipher_round
  import cipher_pkg::*;
(
  input  logic [0:3][0:3][7:0] st,
  input  logic [0:3][0:3][7:0] rk,
  input  logic [7:0]           rcon,
  input  logic                 last,
  output logic [0:3][0:3][7:0] nst,
  output logic [0:3][0:3][7:0] nrk
);

  state_t sb, sr, mc;
  byte_t  tmp [0:3];

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sb[r][c] = SBOX[st[r][c]];
      assign sr[r][c] = sb[r][(c + r) % 4];
    end

    // RotWord + SubWord on the last key column; rcon only touches row 0.
    assign tmp[r] = SBOX[rk[(r + 1) % 4][3]] ^ ((r == 0) ? rcon : 8'h00);

    // Each new key column is the running XOR of the old columns, so it is
    // written out in full to keep nrk free of self-dependence.
    assign nrk[r][0] = tmp[r] ^ rk[r][0];
    assign nrk[r][1] = tmp[r] ^ rk[r][0] ^ rk[r][1];
    assign nrk[r][2] = tmp[r] ^ rk[r][0] ^ rk[r][1] ^ rk[r][2];
    assign nrk[r][3] = tmp[r] ^ rk[r][0] ^ rk[r][1] ^ rk[r][2] ^ rk[r][3];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[0][c] = xtime(sr[0][c]) ^ xtime(sr[1][c]) ^ sr[1][c] ^ sr[2][c] ^ sr[3][c];
    assign mc[1][c] = sr[0][c] ^ xtime(sr[1][c]) ^ xtime(sr[2][c]) ^ sr[2][c] ^ sr[3][c];
    assign mc[2][c] = sr[0][c] ^ sr[1][c] ^ xtime(sr[2][c]) ^ xtime(sr[3][c]) ^ sr[3][c];
    assign mc[3][c] = xtime(sr[0][c]) ^ sr[0][c] ^ sr[1][c] ^ sr[2][c] ^ xtime(sr[3][c]);
  end

  assign nst = (last ? sr : mc) ^ nrk;

endmodule

// File: rtl/cipher_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
// Optional block counter output enabled by CIPHER_CTRL_BLOCK_CNT_EN.
module cipher_ctrl
  import cipher_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:3][0:3][7:0] key,
  input  logic [0:3][0:3][7:0] data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:3][0:3][7:0] o
`ifdef CIPHER_CTRL_BLOCK_CNT_EN
  ,
  output logic [31:0]          blk_cnt
`endif
);

  fsm_t       state, state_nxt;
  state_t     st, rk, nst, nrk;
  logic [3:0] rnd;
  logic       last;

  assign last = (rnd == 4'd10);

  cipher_round u_round (
    .st   (st),
    .rk   (rk),
    .rcon (RCON[rnd]),
    .last (last),
    .nst  (nst),
    .nrk  (nrk)
  );

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every update in this block
  // sees the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well, not just the FSM, so
      // o reads zero after reset instead of stale ciphertext.
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
      rk    <= '0;
      o     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            st  <= data ^ key;
            rk  <= key;
            rnd <= 4'd1;
          end
        end
        ROUND: begin
          st  <= nst;
          rk  <= nrk;
          rnd <= rnd + 4'd1;
          if (last) o <= nst;   // o only changes when a new result lands
        end
        default: ;
      endcase
    end
  end

`ifdef CIPHER_CTRL_BLOCK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                             blk_cnt <= '0;
    else if (state == DONE && out_ready) blk_cnt <= blk_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cipher_ctrl.sv
// Directed bench for cipher_ctrl using FIPS-197 vectors; covers latency,
// backpressure, mid-operation reset and back-to-back throughput.
module tb_cipher_ctrl;
  import cipher_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK  = 128'hdeadbeef0123456789abcdeffedcba98;

  logic   clk = 1'b0;
  logic   rst, in_valid, in_ready, out_valid, out_ready;
  state_t key, data, o;
`ifdef CIPHER_CTRL_BLOCK_CNT_EN
  logic [31:0] blk_cnt;
`endif

  int checks = 0;
  int failures = 0;

  cipher_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o)
`ifdef CIPHER_CTRL_BLOCK_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FIPS byte i lives at [i%4][i/4].
  function automatic state_t to_state(input logic [127:0] h);
    state_t s;
    logic [127:0] t;
    logic [1:0] r, c;
    s = '0;
    t = h;
    for (int i = 0; i < 16; i++) begin
      r = i[1:0];
      c = i[3:2];
      s[r][c] = t[127:120];
      t = t << 8;
    end
    return s;
  endfunction

  function automatic logic [127:0] to_hex(input state_t s);
    logic [127:0] t;
    logic [1:0] r, c;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      r = i[1:0];
      c = i[3:2];
      t = {t[119:0], s[r][c]};
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a block, waits (bounded) for in_ready and steps through the
  // accept edge, then scrambles the inputs to prove they are not resampled.
  task automatic send(input logic [127:0] k, input logic [127:0] d);
    int n;
    key = to_state(k);
    data = to_state(d);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    key = to_state(JUNK);
    data = to_state(~JUNK);
  endtask

  // Counts cycles after the accept edge until out_valid rises.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    key = '0; data = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_o got=%h exp=0", to_hex(o)); end
`ifdef CIPHER_CTRL_BLOCK_CNT_EN
    checks++;
    if (blk_cnt !== 32'd0) begin failures++; $display("FAIL reset_blk_cnt got=%0d exp=0", blk_cnt); end
`endif
  endtask

  task automatic test_fips_b();
    int lat;
    out_ready = 1'b1;
    send(KEY_B, PT_B);
    wait_out(lat);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL fips_b_latency got=%0d exp=10 cycles after accept", lat); end
    checks++;
    if (to_hex(o) !== CT_B) begin failures++; $display("FAIL fips_b_o got=%h exp=%h", to_hex(o), CT_B); end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fips_b_handshake in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_fips_c1();
    int lat;
    out_ready = 1'b1;
    send(KEY_C, PT_C);
    wait_out(lat);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL fips_c1_latency got=%0d exp=10", lat); end
    checks++;
    if (to_hex(o) !== CT_C) begin failures++; $display("FAIL fips_c1_o got=%h exp=%h", to_hex(o), CT_C); end
    tick(); tick(); tick();
    checks++;
    if (to_hex(o) !== CT_C) begin failures++; $display("FAIL fips_c1_o_hold_idle got=%h exp=%h", to_hex(o), CT_C); end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    send(KEY_C, PT_C);
    wait_out(lat);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid_timeout got=%b exp=1", out_valid); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        key = to_state(KEY_B); data = to_state(PT_B); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      checks++;
      if (to_hex(o) !== CT_C || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        bad++;
        if (bad < 4)
          $display("FAIL bp_hold cyc=%0d o=%h in_ready=%b out_valid=%b exp o=%h 0/1",
                   i, to_hex(o), in_ready, out_valid, CT_C);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || to_hex(o) !== CT_C) begin
      failures++;
      $display("FAIL bp_ignored_pulse in_ready=%b o=%h exp 1 %h", in_ready, to_hex(o), CT_C);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    out_ready = 1'b1;
    send(KEY_B, PT_B);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    checks++;
    if (o !== '0) begin failures++; $display("FAIL rst_mid_o got=%h exp=0", to_hex(o)); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_mid_dropped out_valid_cycles=%0d exp=0", seen); end
    send(KEY_B, PT_B);
    wait_out(lat);
    checks++;
    if (lat !== 10 || to_hex(o) !== CT_B) begin
      failures++;
      $display("FAIL rst_mid_next lat=%0d o=%h exp 10 %h", lat, to_hex(o), CT_B);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int     acc_cnt, out_cnt, cyc;
    int     acc_cyc [2];
    state_t res [2];
    logic   acc, hs;
    acc_cnt = 0; out_cnt = 0; cyc = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    res[0] = '0; res[1] = '0;
    out_ready = 1'b1;
    key = to_state(KEY_B); data = to_state(PT_B); in_valid = 1'b1;
    while (out_cnt < 2 && cyc < 80) begin
      acc = in_ready & in_valid;
      hs = out_valid & out_ready;
      if (hs) begin
        res[out_cnt] = o;
        out_cnt++;
      end
      tick();
      cyc++;
      if (acc && acc_cnt < 2) begin
        acc_cyc[acc_cnt] = cyc;
        acc_cnt++;
        if (acc_cnt == 1) begin key = to_state(KEY_C); data = to_state(PT_C); end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cnt !== 2 || out_cnt !== 2) begin
      failures++;
      $display("FAIL b2b_counts accepts=%0d outputs=%0d exp 2/2", acc_cnt, out_cnt);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 12) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=12", acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (to_hex(res[0]) !== CT_B) begin failures++; $display("FAIL b2b_first got=%h exp=%h", to_hex(res[0]), CT_B); end
    checks++;
    if (to_hex(res[1]) !== CT_C) begin failures++; $display("FAIL b2b_second got=%h exp=%h", to_hex(res[1]), CT_C); end
  endtask

`ifdef CIPHER_CTRL_BLOCK_CNT_EN
  task automatic test_blk_cnt();
    int lat;
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(KEY_C, PT_C);
      wait_out(lat);
      tick();
    end
    checks++;
    if (blk_cnt !== 32'd3) begin failures++; $display("FAIL blk_cnt_three got=%0d exp=3", blk_cnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (blk_cnt !== 32'd0) begin failures++; $display("FAIL blk_cnt_reset got=%0d exp=0", blk_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef CIPHER_CTRL_BLOCK_CNT_EN
    test_blk_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
